// File: rtl/tdm_demux1x4.sv
// tdm_demux1x4: HUNT/LOCK framed 1:4 TDM demultiplexer with whole-frame output update.
// Optional framing error counter enabled by defining TDM_ERRCNT_EN.
module tdm_demux1x4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  input  logic         sof,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [1:0]   s,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [7:0]   err_cnt
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t         r_state, w_state_nxt;
  logic [1:0]     r_s, w_s_nxt;
  logic [W-1:0]   r_h0, r_h1, r_h2;
  logic [W-1:0]   r_y0, r_y1, r_y2, r_y3;
  logic           r_fv, r_err;
  logic           w_err, w_load, w_wr0, w_wr1, w_wr2;
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_err       = 1'b0;
    w_load      = 1'b0;
    w_wr0       = 1'b0;
    w_wr1       = 1'b0;
    w_wr2       = 1'b0;
    if (in_valid) begin
      if (r_state == HUNT) begin
        if (sof) begin
          w_wr0       = 1'b1;
          w_s_nxt     = 2'd1;
          w_state_nxt = LOCK;
        end
      end else if (sof && r_s != 2'd0) begin
        // resync: the sof beat restarts the frame as slot 0
        w_err   = 1'b1;
        w_wr0   = 1'b1;
        w_s_nxt = 2'd1;
      end else begin
        w_wr0   = r_s == 2'd0;
        w_wr1   = r_s == 2'd1;
        w_wr2   = r_s == 2'd2;
        w_load  = r_s == 2'd3;
        w_s_nxt = r_s + 2'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_s     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h0  <= '0;
      r_h1  <= '0;
      r_h2  <= '0;
      r_y0  <= '0;
      r_y1  <= '0;
      r_y2  <= '0;
      r_y3  <= '0;
      r_fv  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_h0  <= w_wr0 ? in : r_h0;
      r_h1  <= w_wr1 ? in : r_h1;
      r_h2  <= w_wr2 ? in : r_h2;
      r_y0  <= w_load ? r_h0 : r_y0;
      r_y1  <= w_load ? r_h1 : r_y1;
      r_y2  <= w_load ? r_h2 : r_y2;
      r_y3  <= w_load ? in : r_y3;
      r_fv  <= w_load;
      r_err <= w_err;
    end
  end
`ifdef TDM_ERRCNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= 8'd0;
    else        r_err_cnt <= (w_err && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif
  assign y0          = r_y0;
  assign y1          = r_y1;
  assign y2          = r_y2;
  assign y3          = r_y3;
  assign s           = r_s;
  assign frame_valid = r_fv;
  assign locked      = r_state == LOCK;
  assign sync_err    = r_err;
endmodule

// File: tb/tb_tdm_demux1x4.sv
// tb_tdm_demux1x4: scoreboard bench; expected frames and error counts are queued by the
// stimulus and popped by a monitor whenever frame_valid or sync_err pulses.
module tb_tdm_demux1x4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_d = 4'h0;
  logic       vld = 1'b0;
  logic       sof_d = 1'b0;
  logic [3:0] y0, y1, y2, y3;
  logic [1:0] s;
  logic       frame_valid, locked, sync_err;
  logic [7:0] err_cnt;
  int         pass_cnt = 0;
  int         tot_cnt = 0;
  int         nerr = 0;
  logic [15:0] frame_q[$];
  logic [7:0]  err_q[$];

  tdm_demux1x4 #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_d), .in_valid(vld), .sof(sof_d),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .s(s),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic beat(input logic [3:0] d, input logic f);
    in_d = d;
    sof_d = f;
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    sof_d = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_err();
`ifdef TDM_ERRCNT_EN
    nerr = (nerr < 255) ? nerr + 1 : 255;
`else
    nerr = 0;
`endif
    err_q.push_back(nerr[7:0]);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && frame_valid) begin
          if (frame_q.size() == 0) chk("fv_unexpected", {31'd0, frame_valid}, 32'd0);
          else chk("frame", {16'd0, y0, y1, y2, y3}, {16'd0, frame_q.pop_front()});
        end
        if (rst_n && sync_err) begin
          if (err_q.size() == 0) chk("err_unexpected", {31'd0, sync_err}, 32'd0);
          else chk("err_cnt", {24'd0, err_cnt}, {24'd0, err_q.pop_front()});
        end
      end
    join_none
    #2;
    chk("rst_async_y", {16'd0, y0, y1, y2, y3}, 32'd0);
    chk("rst_async_lock", {31'd0, locked}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_s", {30'd0, s}, 32'd0);
    chk("rst_fv_err", {30'd0, frame_valid, sync_err}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    beat(4'h9, 1'b0);
    beat(4'h8, 1'b0);
    chk("hunt_s", {30'd0, s}, 32'd0);
    chk("hunt_lock", {31'd0, locked}, 32'd0);
    chk("hunt_y", {16'd0, y0, y1, y2, y3}, 32'd0);
    sof_d = 1'b1;
    idle(1);
    sof_d = 1'b0;
    chk("sof_novalid", {31'd0, locked}, 32'd0);
    beat(4'h1, 1'b1);
    chk("lock_s1", {29'd0, locked, s}, 32'h5);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    frame_q.push_back(16'h1234);
    beat(4'h4, 1'b0);
    chk("frame1_lock", {29'd0, locked, s}, 32'h4);
    idle(3);
    chk("hold_y", {16'd0, y0, y1, y2, y3}, 32'h1234);
    beat(4'h5, 1'b1);
    idle(3);
    beat(4'h6, 1'b0);
    idle(3);
    beat(4'h7, 1'b0);
    idle(3);
    chk("gap_nopartial", {16'd0, y0, y1, y2, y3}, 32'h1234);
    chk("gap_s", {30'd0, s}, 32'd3);
    frame_q.push_back(16'h5678);
    beat(4'h8, 1'b0);
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    frame_q.push_back(16'hABCD);
    beat(4'hD, 1'b0);
    beat(4'hE, 1'b1);
    beat(4'hF, 1'b0);
    beat(4'h0, 1'b0);
    frame_q.push_back(16'hEF01);
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b1);
    beat(4'h3, 1'b0);
    exp_err();
    beat(4'h7, 1'b1);
    chk("err_s", {30'd0, s}, 32'd1);
    chk("err_y_held", {16'd0, y0, y1, y2, y3}, 32'hEF01);
    beat(4'h4, 1'b0);
    beat(4'h5, 1'b0);
    frame_q.push_back(16'h7456);
    beat(4'h6, 1'b0);
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    exp_err();
    beat(4'h9, 1'b1);
    chk("err_s3_s", {29'd0, locked, s}, 32'h5);
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b0);
    frame_q.push_back(16'h9ABC);
    beat(4'hC, 1'b0);
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    rst_n = 1'b0;
    nerr = 0;
    #2;
    chk("midrst_y", {16'd0, y0, y1, y2, y3}, 32'd0);
    chk("midrst_state", {24'd0, locked, s, frame_valid, sync_err, 3'd0}, 32'd0);
    chk("midrst_errcnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(4'hE, 1'b0);
    chk("post_rst_hunt", {29'd0, locked, s}, 32'd0);
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    frame_q.push_back(16'hABCD);
    beat(4'hD, 1'b0);
    beat(4'h0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      exp_err();
      beat(4'h3, 1'b1);
    end
`ifdef TDM_ERRCNT_EN
    chk("errcnt_sat", {24'd0, err_cnt}, 32'd255);
`else
    chk("errcnt_off", {24'd0, err_cnt}, 32'd0);
`endif
    idle(4);
    chk("frames_left", frame_q.size(), 32'd0);
    chk("errs_left", err_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
